// File: rtl/piso_pkg.sv
// Shared types for the parallel-in serial-out shift register.
// Holds the FSM state encoding and the default parallel word width.
// Optional feature macro: PISO_PARITY_EN adds the PARITY state.
package piso_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef PISO_PARITY_EN
    , PARITY = 2'd2
`endif
  } state_t;

endpackage

// File: rtl/piso_bit_cell.sv
// One stage of the shift register: a 2:1 load/shift select feeding one flop.
// Latency: q follows the selected input one clock after load or shift.
// Backpressure: none; the cell holds its value when neither load nor shift is set.
// Ports: clk, rst_n (async active-low); load/shift enables; load_bit is the
//        parallel input, shift_bit comes from the lower neighbour; q is the stored bit.
module piso_bit_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic shift,
  input  logic load_bit,
  input  logic shift_bit,
  output logic q
);

  logic d;

  // Load wins over shift; the flop only updates when one of them is active.
  assign d = load ? load_bit : shift_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (load || shift) begin
      q <= d;
    end
  end

endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shifter: accepts a WIDTH-bit word and emits it MSB-first.
// Latency: first serial bit in the cycle after the handshake; word period WIDTH+1 (WIDTH+2 with parity).
// Backpressure: in_ready is high only in IDLE; in_valid/in_data are ignored while busy.
// Ports: clk, rst_n (async active-low); in_valid/in_data/in_ready upstream handshake;
//        sout/sout_valid serial stream; busy while serialising; done pulses on the final bit.
// Build option: define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_shift_reg
  import piso_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shift_in;
  logic             load;
  logic             shifting;
  logic             last_data;

  assign in_ready  = (state == IDLE);
  assign load      = in_valid && in_ready;
  assign shifting  = (state == SHIFT);
  // cnt holds the number of data bits already emitted, so WIDTH-1 marks the last one.
  assign last_data = shifting && (cnt == LAST_CNT);

  // Left shift: each cell takes its lower neighbour, bit 0 fills with zero.
  assign shift_in = {shreg[WIDTH-2:0], 1'b0};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    piso_bit_cell u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .shift     (shifting),
      .load_bit  (in_data[i]),
      .shift_bit (shift_in[i]),
      .q         (shreg[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= SHIFT;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
`ifdef PISO_PARITY_EN
            state <= PARITY;
`else
            state <= IDLE;
`endif
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PISO_PARITY_EN
  logic parity_q;
  logic in_parity;

  // Captured from the word as loaded; the register contents are destroyed by shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else if (load) begin
      parity_q <= ^in_data;
    end
  end

  assign in_parity  = (state == PARITY);
  assign sout_valid = shifting || in_parity;
  assign sout       = shifting ? shreg[WIDTH-1] : (in_parity & parity_q);
  assign done       = last_data || in_parity;
`else
  assign sout_valid = shifting;
  assign sout       = shifting & shreg[WIDTH-1];
  assign done       = last_data;
`endif

  assign busy = sout_valid;

endmodule

// File: doc/piso_shift_reg.md
PISO_SHIFT_REG -- requirements
Module: piso_shift_reg

Interface
REQ-001 Parameter: WIDTH, default 8, parallel word width; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  upstream presents a word on in_data.
REQ-005 Port: in_data  input  WIDTH  parallel word to serialise.
REQ-006 Port: in_ready  output  1  block accepts a word this cycle.
REQ-007 Port: sout  output  1  serial data bit.
REQ-008 Port: sout_valid  output  1  sout carries a valid bit this cycle.
REQ-009 Port: busy  output  1  serialisation in progress.
REQ-010 Port: done  output  1  one-cycle pulse marking the last serial bit of a word.

Function
REQ-011 The FSM SHALL have states IDLE, SHIFT and PARITY (PARITY exists only when PISO_PARITY_EN is defined).
REQ-012 in_ready SHALL be 1 exactly when state is IDLE; the handshake occurs on an edge where in_valid && in_ready.
REQ-013 On handshake the block SHALL load in_data into the shift register, clear the bit counter and enter SHIFT.
REQ-014 In SHIFT, sout SHALL carry MSB-first: bit WIDTH-1 in the first cycle after handshake, then bit WIDTH-k in cycle k, for k = 1..WIDTH.
REQ-015 Each SHIFT cycle SHALL shift the register left by one and increment a counter of width $clog2(WIDTH+1).
REQ-016 After the last data bit, the FSM SHALL go to PARITY if enabled, otherwise to IDLE.
REQ-017 sout_valid and busy SHALL be 1 in SHIFT and PARITY, 0 in IDLE.
REQ-018 sout SHALL be 0 whenever sout_valid is 0.
REQ-019 done SHALL be 1 only in the cycle carrying the final serial bit (last data bit, or the parity bit when enabled).
REQ-020 in_ready SHALL return to 1 in the cycle after done; the minimum word period is WIDTH+1 cycles (WIDTH+2 with parity).
REQ-021 in_valid and in_data SHALL be ignored while busy; a held in_valid is accepted on the first IDLE edge.

Reset
REQ-022 rst_n low SHALL immediately force: state IDLE, shift register 0, counter 0, sout 0, sout_valid 0, busy 0, done 0, in_ready 1.
REQ-023 Reset asserted mid-word SHALL abort the word without emitting further bits or a done pulse.
REQ-024 The first handshake after rst_n deasserts SHALL behave exactly as in REQ-013.

Configuration
REQ-025 Macro PISO_PARITY_EN SHALL control the parity feature.
- Defined: one extra PARITY cycle after the data bits, with sout equal to the even-parity bit (XOR of the loaded word), sout_valid 1 and done 1.
- Undefined: no PARITY state, no parity logic, done on the last data bit.

Structure
REQ-026 Shared package piso_pkg SHALL hold the state enum typedef and the WIDTH default constant.
REQ-027 Sub-module piso_bit_cell (2:1 load/shift select feeding one flop) SHALL be instantiated WIDTH times to form the shift register.
REQ-028 The parity bit SHALL be computed at load time and registered, not recomputed from the shifting data.

Verification
REQ-029 WIDTH=8: load 0xA5 -> sout 1,0,1,0,0,1,0,1 over 8 cycles; done in cycle 8; in_ready 1 in cycle 9.
REQ-030 PISO_PARITY_EN defined: 0xA5 -> 8 data bits then parity 0; 0x07 -> parity 1; done on the parity cycle.
REQ-031 in_valid held high with 0x3C then 0xC3 -> 0x3C serialised, 0xC3 accepted on the first IDLE edge, no bits dropped or duplicated.
REQ-032 rst_n pulsed low in cycle 4 of 0xFF -> sout_valid, busy and sout drop to 0 immediately; no done pulse; in_ready 1.
REQ-033 WIDTH=2: load 2'b10 -> sout 1,0; done in cycle 2; back-to-back accept in cycle 3.
REQ-034 Idle with in_valid 0 for 20 cycles -> sout_valid, busy and done stay 0; in_ready stays 1.
